das_delay_scheduler: RTL
========================

Name: das_delay_scheduler

Overview:
Sequencer for the delay-and-sum beamformer datapath, sitting between the mic_array capture stream and the AD1939 DAC path. It collects one sample per microphone per frame into a circular per-channel delay memory. After each complete frame it schedules one delayed-tap read per channel, accumulates the taps, and emits one averaged beam sample. Per-channel steering delays come from a double-buffered register port written by the HPS.

Parameters:
NUM_MICS, 16, microphone channel count; power of 2, >=2
DATA_W, 24, signed sample width
DEPTH, 64, frames held per channel; power of 2
DLY_W, 8, delay register width
(local) CH_W = clog2(NUM_MICS); PTR_W = clog2(DEPTH); ACC_W = DATA_W+CH_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  scheduler can accept a sample
in_channel  in  CH_W  channel index of in_data
in_data  in  DATA_W  signed mic sample
cfg_write  in  1  delay register write strobe
cfg_read  in  1  delay register read strobe
cfg_address  in  CH_W  channel select
cfg_writedata  in  DLY_W  delay in frames
cfg_readdata  out  DLY_W  shadow delay value, registered, 1-cycle read latency
out_valid  out  1  one-cycle beam sample strobe
out_data  out  DATA_W  signed beam sample
busy  out  1  high in SUM state
err_seq  out  1  one-cycle pulse on an out-of-order channel

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: in_ready=0 while reset is high and 1 on the first cycle after. out_valid=0, out_data=0, busy=0, err_seq=0, cfg_readdata=0. All shadow and active delays=0, wr_ptr=0, fill=0, expected_ch=0, accumulator=0.
- Memory: NUM_MICS x DEPTH words of DATA_W. Address = {channel, frame pointer}. Single read port, 1-cycle read latency.
- COLLECT state (in_ready=1):
  - A sample is accepted when in_valid and in_ready are both high.
  - If in_channel==expected_ch: write to mem[ch][wr_ptr] and increment expected_ch.
  - Accepting channel NUM_MICS-1 moves the block to SUM.
- Out-of-order channel (in_channel!=expected_ch):
  - Sample is dropped, err_seq pulses, expected_ch is forced to 0.
  - If in_channel==0, the sample is instead accepted as the start of a new frame and expected_ch becomes 1; err_seq still pulses.
  - A partial frame is discarded: wr_ptr is not advanced and its slots are overwritten later.
- Entering SUM:
  - Active delays are loaded from the shadow registers.
  - A cfg_write in the same cycle updates both shadow and active (write-first).
  - fill = min(fill+1, DEPTH) takes effect for this frame.
- SUM timing (last sample accepted at cycle T):
  - Cycles T+1..T+NUM_MICS: one read issued per channel, 0 to N-1.
  - d_eff = min(delay, DEPTH-1). Read address = (wr_ptr - d_eff) mod DEPTH.
  - If d_eff >= fill, the tap contributes 0 (unwritten history) regardless of memory contents.
  - Taps are sign-extended to ACC_W and summed; no overflow is possible.
  - in_ready=0 and busy=1 throughout SUM.
- Output at cycle T+NUM_MICS+2:
  - out_valid=1 for one cycle; out_data = acc >>> CH_W (arithmetic shift, truncating toward -inf).
  - wr_ptr increments mod DEPTH, the block returns to COLLECT, and in_ready=1 in the same cycle.
- Config port:
  - cfg_write updates the shadow register at any time, including during SUM.
  - A write during SUM affects the next frame only.
  - Values are stored unclamped; clamping applies only when forming the read address.
  - cfg_read returns the shadow value on the next cycle.
- Reset mid-SUM: frame is aborted, no out_valid, all state returns to reset values.
- Simultaneous cfg_write and cfg_read to the same address: read returns the old value.

Test Plan:
- Bench parameters: NUM_MICS=4, DATA_W=24, DEPTH=8.
- Delays all 0; frame ch0..3 = 100, 200, 300, 400 with last accept at cycle T -> out_valid only at T+6, out_data=250; in_ready=0 during T+1..T+5.
- delay[1]=2; four frames, all channels = 16, 32, 48, 64 -> out_data = 12, 24, 40, 56 (ch1 tap is 0 until fill>2). Writing delay[1]=0 during the 4th frame's SUM leaves 56 unchanged; the 5th frame (80) gives 80.
- All channels = -8, delays 0 -> out_data=-8; channels -1, 0, 0, 0 -> out_data=-1.
- delay[2]=200 -> cfg_readdata=200. Ten frames with value = frame index k -> for k>=7, ch2 tap equals k-7 (clamped to 7).
- Out-of-order: ch0, ch2 -> err_seq pulse, no output. Then ch0..3 = 4, 4, 4, 4 -> out_data=4, wr_ptr advanced once. A second ch0 mid-frame restarts the frame and pulses err_seq.
- Reset pulsed at T+3 during SUM -> no out_valid; in_ready=1 one cycle after reset falls; next frame is treated as fill=1 (delayed taps read 0).

Source files
------------

// File: rtl/das_delay_scheduler.sv
// Delay-and-sum beamformer sequencer: collects one sample per mic per frame into a
// circular per-channel history, then reads one steered tap per channel and emits the average.
module das_delay_scheduler #(
  parameter int NUM_MICS = 16,
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 64,
  parameter int DLY_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(NUM_MICS)-1:0] in_channel,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        cfg_write,
  input  logic                        cfg_read,
  input  logic [$clog2(NUM_MICS)-1:0] cfg_address,
  input  logic [DLY_W-1:0]            cfg_writedata,
  output logic [DLY_W-1:0]            cfg_readdata,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        busy,
  output logic                        err_seq
);

  localparam int CH_W   = $clog2(NUM_MICS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ACC_W  = DATA_W + CH_W;
  localparam int FILL_W = PTR_W + 1;
  localparam int ADDR_W = CH_W + PTR_W;

  localparam logic [CH_W-1:0]   CH_ZERO   = CH_W'(0);
  localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_MICS - 1);
  localparam logic [CH_W:0]     CNT_ONE   = (CH_W + 1)'(1);
  localparam logic [CH_W:0]     LAST_CNT  = (CH_W + 1)'(NUM_MICS);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);

  typedef enum logic [0:0] {ST_COLLECT, ST_SUM} state_t;

  // Delay is stored raw; it saturates at the oldest slot only when forming the read address.
  function automatic logic [PTR_W-1:0] clamp_delay(input logic [DLY_W-1:0] dly);
    logic [31:0] dly_ext;
    dly_ext = 32'(dly);
    if (dly_ext >= 32'(DEPTH - 1)) begin
      return PTR_W'(DEPTH - 1);
    end else begin
      return dly_ext[PTR_W-1:0];
    end
  endfunction

  state_t                    state_r;
  logic [CH_W-1:0]           expected_ch_r;
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [FILL_W-1:0]         fill_r;
  logic [CH_W:0]             cnt_r;
  logic [DLY_W-1:0]          shadow_r [NUM_MICS];
  logic [DLY_W-1:0]          active_r [NUM_MICS];
  logic signed [ACC_W-1:0]   acc_r;
  logic [DATA_W-1:0]         mem_r [2**ADDR_W];
  logic signed [DATA_W-1:0]  mem_q_r;
  logic                      tap_zero_r;
  logic                      rd_vld_r;
  logic                      in_ready_r;
  logic [DLY_W-1:0]          cfg_readdata_r;
  logic                      out_valid_r;
  logic [DATA_W-1:0]         out_data_r;
  logic                      busy_r;
  logic                      err_seq_r;

  logic                      accept_s;
  logic                      in_order_s;
  logic                      wr_en_s;
  logic [ADDR_W-1:0]         wr_addr_s;
  logic [CH_W-1:0]           rd_ch_s;
  logic [PTR_W-1:0]          d_eff_s;
  logic [ADDR_W-1:0]         rd_addr_s;
  logic                      rd_en_s;
  logic                      rd_zero_s;
  logic signed [ACC_W-1:0]   tap_s;
  logic signed [ACC_W-1:0]   sum_s;

  assign accept_s   = in_valid & in_ready_r;
  assign in_order_s = (in_channel == expected_ch_r);
  // An out-of-order channel 0 still lands in memory because it opens a fresh frame.
  assign wr_en_s    = accept_s & (in_order_s | (in_channel == CH_ZERO));
  assign wr_addr_s  = {in_channel, wr_ptr_r};
  assign rd_ch_s    = cnt_r[CH_W-1:0];
  assign d_eff_s    = clamp_delay(active_r[rd_ch_s]);
  assign rd_addr_s  = {rd_ch_s, wr_ptr_r - d_eff_s};
  assign rd_en_s    = (state_r == ST_SUM) && (cnt_r != LAST_CNT);
  assign rd_zero_s  = ({1'b0, d_eff_s} >= fill_r);

  // Sign-extend the returned tap, masking history that was never written.
  always_comb begin
    tap_s = '0;
    if (rd_vld_r && !tap_zero_r) begin
      tap_s = {{CH_W{mem_q_r[DATA_W-1]}}, mem_q_r};
    end else begin
      tap_s = '0;
    end
    sum_s = acc_r + tap_s;
  end

  // Sample history RAM with one registered read port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= in_data;
    end
    if (rd_en_s) begin
      mem_q_r <= mem_r[rd_addr_s];
    end
  end

  // Frame sequencing, delay registers and output staging.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_COLLECT;
      expected_ch_r  <= CH_ZERO;
      wr_ptr_r       <= '0;
      fill_r         <= '0;
      cnt_r          <= '0;
      shadow_r       <= '{default: '0};
      active_r       <= '{default: '0};
      acc_r          <= '0;
      tap_zero_r     <= 1'b0;
      rd_vld_r       <= 1'b0;
      in_ready_r     <= 1'b0;
      cfg_readdata_r <= '0;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      busy_r         <= 1'b0;
      err_seq_r      <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      err_seq_r   <= 1'b0;
      if (cfg_write) begin
        shadow_r[cfg_address] <= cfg_writedata;
      end
      if (cfg_read) begin
        cfg_readdata_r <= shadow_r[cfg_address];
      end
      case (state_r)
        ST_COLLECT: begin
          in_ready_r <= 1'b1;
          rd_vld_r   <= 1'b0;
          if (accept_s) begin
            if (in_order_s) begin
              if (expected_ch_r == LAST_CH) begin
                expected_ch_r <= CH_ZERO;
                state_r       <= ST_SUM;
                in_ready_r    <= 1'b0;
                busy_r        <= 1'b1;
                cnt_r         <= '0;
                acc_r         <= '0;
                active_r      <= shadow_r;
                if (cfg_write) begin
                  active_r[cfg_address] <= cfg_writedata;
                end
                fill_r <= (fill_r == FILL_MAX) ? FILL_MAX : fill_r + FILL_ONE;
              end else begin
                expected_ch_r <= expected_ch_r + CH_ONE;
              end
            end else begin
              err_seq_r     <= 1'b1;
              expected_ch_r <= (in_channel == CH_ZERO) ? CH_ONE : CH_ZERO;
            end
          end
        end
        ST_SUM: begin
          rd_vld_r   <= rd_en_s;
          tap_zero_r <= rd_zero_s;
          if (cnt_r == LAST_CNT) begin
            // Final tap arrives this cycle; fold it straight into the output.
            out_valid_r <= 1'b1;
            out_data_r  <= sum_s[ACC_W-1:CH_W];
            wr_ptr_r    <= wr_ptr_r + PTR_ONE;
            acc_r       <= '0;
            state_r     <= ST_COLLECT;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= ST_COLLECT;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign cfg_readdata = cfg_readdata_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign busy         = busy_r;
  assign err_seq      = err_seq_r;

endmodule
